// File: rtl/nt_node_activity_monitor.sv
// nt_node_activity_monitor
// Observation stage for the single-bit output of an Nt-node subcircuit.
// Over a programmable window of WINDOW_LEN sampled cycles it counts ones
// and sample-to-sample toggles, then flags the node as rare (few toggles)
// or stuck (no toggles). Results hold until the next accepted win_start.
// Optional feature: define NODE_MON_HIST_EN to add an 8-bit history port
// holding the last eight counted samples (newest in bit 0).
module nt_node_activity_monitor #(
    parameter int WINDOW_LEN  = 1024,
    parameter int CNT_W       = 16,
    parameter int RARE_THRESH = 4
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             node_in,
    input  logic             win_start,
    input  logic             win_abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             rare_flag,
    output logic             stuck_flag
`ifdef NODE_MON_HIST_EN
    ,
    output logic [7:0]       hist
`endif
);

    // The window counter only has to reach WINDOW_LEN-1.
    localparam int WC_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // One extra bit so a threshold of exactly 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0]   RARE_LIM = (CNT_W + 1)'(RARE_THRESH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic             node_q;
    logic             prev_q;
    logic [WC_W-1:0]  win_cnt;
    logic [CNT_W-1:0] ones_next;
    logic [CNT_W-1:0] toggle_next;

    // Register the observed net every cycle, independent of the FSM state.
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            node_q <= 1'b0;
        end else begin
            node_q <= node_in;
        end
    end

    // Saturating next values of both counters for the sample held in node_q.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ones_next   = ones_cnt;
        toggle_next = toggle_cnt;
        if (node_q && (ones_cnt != CNT_MAX)) begin
            ones_next = ones_cnt + 1'b1;
        end
        if ((node_q ^ prev_q) && (toggle_cnt != CNT_MAX)) begin
            toggle_next = toggle_cnt + 1'b1;
        end
    end

    // Window FSM with registered busy/done, counters and flags.
    // An abort still counts the sample of its own cycle but suppresses done
    // and leaves the flags at 0, even in the last RUN cycle.
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones_cnt   <= '0;
            toggle_cnt <= '0;
            rare_flag  <= 1'b0;
            stuck_flag <= 1'b0;
            prev_q     <= 1'b0;
            win_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_start) begin
                        state      <= S_ARM;
                        busy       <= 1'b1;
                        ones_cnt   <= '0;
                        toggle_cnt <= '0;
                        rare_flag  <= 1'b0;
                        stuck_flag <= 1'b0;
                    end
                end
                S_ARM: begin
                    // First sample seeds prev_q and never counts as a toggle.
                    prev_q   <= node_q;
                    ones_cnt <= CNT_W'(node_q);
                    win_cnt  <= WC_W'(1);
                    if (win_abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    ones_cnt   <= ones_next;
                    toggle_cnt <= toggle_next;
                    prev_q     <= node_q;
                    win_cnt    <= win_cnt + 1'b1;
                    if (win_abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (win_cnt == WC_LAST) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        rare_flag  <= ({1'b0, toggle_next} < RARE_LIM);
                        stuck_flag <= (toggle_next == '0);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef NODE_MON_HIST_EN
    // History of the samples counted in ARM/RUN; cleared when a window is accepted.
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            hist <= '0;
        end else if ((state == S_IDLE) && win_start) begin
            hist <= '0;
        end else if ((state == S_ARM) || (state == S_RUN)) begin
            hist <= {hist[6:0], node_q};
        end
    end
`endif

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// Self-checking bench for nt_node_activity_monitor.
// dut1 (WINDOW_LEN=16, CNT_W=16) is checked every cycle against a
// window-level model that tallies the logged input samples directly;
// dut2 (WINDOW_LEN=8, CNT_W=3) exercises saturation with literal checks.
module tb_nt_node_activity_monitor;

    localparam int W    = 16;
    localparam int CW   = 16;
    localparam int RT   = 4;
    localparam int W2   = 8;
    localparam int CW2  = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam int LOGN = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          node_in = 1'b0, win_start = 1'b0, win_abort = 1'b0;
    logic          busy, done, rare_flag, stuck_flag;
    logic [CW-1:0] ones_cnt, toggle_cnt;

    logic           n2 = 1'b0, s2 = 1'b0, a2 = 1'b0;
    logic           busy2, done2, rare2, stuck2;
    logic [CW2-1:0] ones2, tog2;
`ifdef NODE_MON_HIST_EN
    logic [7:0] hist1, hist2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nt_node_activity_monitor #(.WINDOW_LEN(W), .CNT_W(CW), .RARE_THRESH(RT)) dut1 (
        .I1470_clk (clk),
        .I1477_rst (rst_n),
        .node_in   (node_in),
        .win_start (win_start),
        .win_abort (win_abort),
        .busy      (busy),
        .done      (done),
        .ones_cnt  (ones_cnt),
        .toggle_cnt(toggle_cnt),
        .rare_flag (rare_flag),
        .stuck_flag(stuck_flag)
`ifdef NODE_MON_HIST_EN
        ,
        .hist      (hist1)
`endif
    );

    nt_node_activity_monitor #(.WINDOW_LEN(W2), .CNT_W(CW2), .RARE_THRESH(RT)) dut2 (
        .I1470_clk (clk),
        .I1477_rst (rst_n),
        .node_in   (n2),
        .win_start (s2),
        .win_abort (a2),
        .busy      (busy2),
        .done      (done2),
        .ones_cnt  (ones2),
        .toggle_cnt(tog2),
        .rare_flag (rare2),
        .stuck_flag(stuck2)
`ifdef NODE_MON_HIST_EN
        ,
        .hist      (hist2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- window-level model of dut1 ----------------
    bit in_log [LOGN];
    int cyc = 0;
    int m_c;
    bit m_active = 1'b0, m_in_done = 1'b0;
    int m_start = 0;
    bit e_busy = 1'b0, e_done = 1'b0, e_rare = 1'b0, e_stuck = 1'b0;
    int e_ones = 0, e_tog = 0;
    int done_count = 0, last_done_cyc = 0, t0 = 0;

    // Count ones and changes over logged samples lo..hi, saturating.
    function automatic void tally(input int lo, input int hi, output int ones, output int tog);
        ones = 0;
        tog  = 0;
        for (int i = lo; i <= hi; i++) begin
            if (in_log[i]) ones++;
            if (i > lo && in_log[i] != in_log[i-1]) tog++;
        end
        if (ones > MAXC) ones = MAXC;
        if (tog > MAXC) tog = MAXC;
    endfunction

    always @(posedge clk) begin
        m_c = cyc;
        if (m_c < LOGN) in_log[m_c] = node_in;
        if (!rst_n) begin
            m_active = 0; m_in_done = 0;
            e_busy = 0; e_done = 0; e_ones = 0; e_tog = 0; e_rare = 0; e_stuck = 0;
        end else begin
            e_done = 0;
            if (m_active) begin
                if (win_abort) begin
                    m_active = 0;
                    e_busy   = 0;
                    tally(m_start, m_c - 1, e_ones, e_tog);
                end else if (m_c == m_start + W) begin
                    m_active  = 0;
                    m_in_done = 1;
                    e_busy    = 0;
                    e_done    = 1;
                    tally(m_start, m_start + W - 1, e_ones, e_tog);
                    e_rare  = (e_tog < RT);
                    e_stuck = (e_tog == 0);
                end
            end else if (m_in_done) begin
                m_in_done = 0;
            end else if (win_start) begin
                m_active = 1; m_start = m_c; e_busy = 1;
                e_ones = 0; e_tog = 0; e_rare = 0; e_stuck = 0;
            end
        end
        cyc = m_c + 1;
        #1;
        check("busy", busy, e_busy);
        check("done", done, e_done);
        if (done) begin
            done_count++;
            last_done_cyc = cyc;
        end
        if (!e_busy) begin
            check("ones_cnt", ones_cnt, e_ones);
            check("toggle_cnt", toggle_cnt, e_tog);
            check("rare_flag", rare_flag, e_rare);
            check("stuck_flag", stuck_flag, e_stuck);
        end
    end

    int done2_count = 0;
    always @(posedge clk) begin
        #1;
        if (done2) done2_count++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic n, input logic s, input logic a);
        @(negedge clk);
        node_in   = n;
        win_start = s;
        win_abort = a;
    endtask

    // pat: 0 const 0, 1 const 1, 2 alternating from 1, 3 four toggles, 4 three toggles
    task automatic run_window(input int pat, input int start_again, input int abort_at, input bit both);
        done_count = 0;
        for (int i = 0; i < W + 9; i++) begin
            logic n;
            case (pat)
                0:       n = 1'b0;
                1:       n = 1'b1;
                2:       n = (i % 2 == 0);
                3:       n = (i >= 2 && i < 4) || (i >= 8 && i < 10);
                default: n = (i >= 2 && i < 4) || (i >= 8);
            endcase
            drive(n, (i == 0) || (i == start_again), (i == abort_at) || (both && i == 0));
            if (i == 0) t0 = cyc;
        end
    endtask

    task automatic expect_win(input string tag, input int dones, input int o, input int t,
                              input logic r, input logic s);
        check({tag, " done_count"}, done_count, dones);
        if (dones == 1) check({tag, " done_latency"}, last_done_cyc - t0, W + 1);
        check({tag, " ones"}, ones_cnt, o);
        check({tag, " toggles"}, toggle_cnt, t);
        check({tag, " rare"}, rare_flag, r);
        check({tag, " stuck"}, stuck_flag, s);
    endtask

    task automatic run_window2(input int pat);
        for (int i = 0; i < W2 + 4; i++) begin
            @(negedge clk);
            n2 = (pat == 1) ? 1'b1 : (i % 2 == 0);
            s2 = (i == 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ones", ones_cnt, 0);
        check("reset toggles", toggle_cnt, 0);
        check("reset rare", rare_flag, 0);
        check("reset stuck", stuck_flag, 0);
        check("reset ones2", ones2, 0);
        rst_n = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);

        run_window(0, -1, W + 1, 0);   // abort in the DONE cycle is ignored
        expect_win("const0", 1, 0, 0, 1'b1, 1'b1);
        run_window(2, W + 1, -1, 0);   // start in the DONE cycle is ignored
        expect_win("alt", 1, 8, 15, 1'b0, 1'b0);
        check("alt idle after", busy, 0);
        run_window(2, 5, -1, 0);       // start mid-window is ignored
        expect_win("alt_restart", 1, 8, 15, 1'b0, 1'b0);
        run_window(2, -1, 8, 0);       // abort at sample 8
        expect_win("abort", 0, 4, 7, 1'b0, 1'b0);
        run_window(2, -1, -1, 1);      // start and abort together in IDLE
        expect_win("start_abort", 1, 8, 15, 1'b0, 1'b0);
        run_window(1, -1, -1, 0);
        expect_win("const1", 1, 16, 0, 1'b1, 1'b1);
        run_window(3, -1, -1, 0);
        expect_win("tog4", 1, 4, 4, 1'b0, 1'b0);
        run_window(4, -1, -1, 0);
        expect_win("tog3", 1, 10, 3, 1'b1, 1'b0);

        // asynchronous reset in the middle of RUN
        for (int i = 0; i < 7; i++) drive((i % 2 == 0), (i == 0), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset ones", ones_cnt, 0);
        check("midreset toggles", toggle_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(2, -1, -1, 0);
        expect_win("after_reset", 1, 8, 15, 1'b0, 1'b0);

        // narrow counters: saturation
        done2_count = 0;
        run_window2(1);
        check("sat done2", done2_count, 1);
        check("sat ones2", ones2, 7);
        check("sat tog2", tog2, 0);
        check("sat rare2", rare2, 1);
        check("sat stuck2", stuck2, 1);
        run_window2(2);
        check("alt2 done2", done2_count, 2);
        check("alt2 ones2", ones2, 4);
        check("alt2 tog2", tog2, 7);
        check("alt2 rare2", rare2, 0);
        check("alt2 stuck2", stuck2, 0);
`ifdef NODE_MON_HIST_EN
        check("hist2", hist2, 8'hAA);
        check("hist1", hist1, 8'hAA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
